// File: rtl/uart_pkg.sv
// uart_pkg: shared UART tx state encoding and line constants; UART_TX_ARB_PARITY_EN adds the PARITY state.
package uart_pkg;
  localparam int UART_DATA_BITS = 8;
  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT = 1'b1;
  localparam logic UART_IDLE_LEVEL = 1'b1;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_ARB_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } uart_tx_state_t;
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester-side bundle of the shared UART transmitter.
interface uart_tx_arbiter_if #(parameter int N_REQ = 4);
  localparam int IW = $clog2(N_REQ);
  logic [N_REQ-1:0] req;
  logic [8*N_REQ-1:0] data_in;
  logic [N_REQ-1:0] ack;
  logic [IW-1:0] gnt_id;
  logic tx;
  logic bsy;
  modport master(output req, data_in, input ack, gnt_id, tx, bsy);
  modport slave(input req, data_in, output ack, gnt_id, tx, bsy);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period divider, one-cycle tick every CLK_DIV clocks, restartable by clr.
module uart_baud_tick #(parameter int CLK_DIV = 16) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(CLK_DIV);
  logic [W-1:0] cnt;
  assign tick = cnt == W'(CLK_DIV - 1);
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one 8N1 UART serializer; UART_TX_ARB_PARITY_EN inserts even parity.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CLK_DIV = 16
) (
  input logic clk,
  input logic rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  uart_tx_state_t state;
  logic [IW-1:0] last, win;
  logic [7:0] shift;
  logic [2:0] bit_idx;
  logic tick, grant;
`ifdef UART_TX_ARB_PARITY_EN
  logic par;
`endif
  // highest priority goes to the requester just after the last winner
  always_comb begin
    win = last;
    for (int i = N_REQ; i >= 1; i--)
      if (bus.req[(int'(last) + i) % N_REQ]) win = IW'((int'(last) + i) % N_REQ);
  end
  assign grant = state == ST_IDLE && |bus.req;
  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (.clk(clk), .rst(rst), .clr(grant), .tick(tick));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      shift <= '0;
      bit_idx <= '0;
      last <= IW'(N_REQ - 1);
      bus.ack <= '0;
      bus.gnt_id <= '0;
      bus.tx <= UART_IDLE_LEVEL;
      bus.bsy <= 1'b0;
`ifdef UART_TX_ARB_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      bus.ack <= '0;
      case (state)
        ST_IDLE: if (grant) begin
          shift <= bus.data_in[8*int'(win) +: 8];
`ifdef UART_TX_ARB_PARITY_EN
          par <= ^bus.data_in[8*int'(win) +: 8];
`endif
          bus.gnt_id <= win;
          last <= win;
          bus.ack <= N_REQ'(1) << win;
          bus.tx <= UART_START_BIT;
          bus.bsy <= 1'b1;
          state <= ST_START;
        end
        ST_START: if (tick) begin
          state <= ST_DATA;
          bit_idx <= '0;
          bus.tx <= shift[0];
        end
        ST_DATA: if (tick) begin
          shift <= shift >> 1;
          bit_idx <= bit_idx + 3'd1;
          if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_ARB_PARITY_EN
            state <= ST_PARITY;
            bus.tx <= par;
`else
            state <= ST_STOP;
            bus.tx <= UART_STOP_BIT;
`endif
          end else bus.tx <= shift[1];
        end
`ifdef UART_TX_ARB_PARITY_EN
        ST_PARITY: if (tick) begin
          state <= ST_STOP;
          bus.tx <= UART_STOP_BIT;
        end
`endif
        ST_STOP: if (tick) begin
          state <= ST_IDLE;
          bus.bsy <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed plus random frames checked against a round-robin/frame model.
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int CD = 4;
`ifdef UART_TX_ARB_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int model_last = N - 1;
  int w;
  uart_tx_arbiter_if #(.N_REQ(N)) bus ();
  uart_tx_arbiter #(.N_REQ(N), .CLK_DIV(CD)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_winner(input logic [N-1:0] r);
    for (int i = 1; i <= N; i++) if (r[(model_last + i) % N]) return (model_last + i) % N;
    return -1;
  endfunction

  function automatic logic frame_bit(input logic [7:0] b, input int p);
    if (p == 0) return 1'b0;
    if (p <= 8) return b[p-1];
    if (NB == 11 && p == 9) return ^b;
    return 1'b1;
  endfunction

  // pulse: mask raised at frame cycle on and dropped at frame cycle off
  task automatic run_frame(input logic keep, input logic [N-1:0] pulse, input int on, input int off,
                           output int waited);
    int ew;
    logic [7:0] b;
    logic [N-1:0] r;
    waited = 0;
    r = bus.req;
    tick();
    while (bus.ack === '0 && waited < 200) begin
      r = bus.req;
      waited++;
      tick();
    end
    chk("ack_seen", 32'(bus.ack !== '0), 1);
    ew = model_winner(r);
    b = bus.data_in[8*((ew < 0) ? 0 : ew) +: 8];
    chk("ack_onehot", 32'(bus.ack), 32'(1) << ew);
    chk("gnt_id", 32'(bus.gnt_id), 32'(ew));
    if (ew >= 0) model_last = ew;
    if (!keep && ew >= 0) bus.req[ew] = 1'b0;
    for (int c = 0; c < NB * CD; c++) begin
      if (c > 0) tick();
      if (c == on) bus.req = bus.req | pulse;
      if (c == off) bus.req = bus.req & ~pulse;
      chk($sformatf("tx_c%0d", c), 32'(bus.tx), 32'(frame_bit(b, c / CD)));
      chk("bsy_frame", 32'(bus.bsy), 1);
      if (c == 1) chk("ack_one_cycle", 32'(bus.ack), 0);
    end
    tick();
    chk("idle_bsy", 32'(bus.bsy), 0);
    chk("idle_tx", 32'(bus.tx), 1);
  endtask

  initial begin
    int acks;
    bus.req = '0;
    bus.data_in = '0;
    tick();
    tick();
    chk("rst_tx", 32'(bus.tx), 1);
    chk("rst_bsy", 32'(bus.bsy), 0);
    chk("rst_ack", 32'(bus.ack), 0);
    chk("rst_gnt", 32'(bus.gnt_id), 0);
    rst = 1'b0;
    // single request, byte A5 from requester 1
    bus.data_in[15:8] = 8'hA5;
    bus.req = 4'b0010;
    run_frame(1'b0, '0, -1, -1, w);
    // simultaneous requests right after reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_last = N - 1;
    bus.data_in = $urandom;
    bus.req = 4'b0101;
    run_frame(1'b0, '0, -1, -1, w);
    run_frame(1'b0, '0, -1, -1, w);
    chk("b2b_gap", 32'(w), 0);
    chk("b2b_gnt2", 32'(bus.gnt_id), 2);
    // fairness with every requester held
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_last = N - 1;
    bus.data_in = $urandom;
    bus.req = '1;
    for (int f = 0; f < 8; f++) begin
      run_frame(1'b1, '0, -1, -1, w);
      chk("fair_order", 32'(bus.gnt_id), 32'(f % N));
    end
    bus.req = '0;
    // reset during DATA bit 3 of a frame for requester 2
    bus.data_in = $urandom;
    bus.req = 4'b0100;
    w = 0;
    tick();
    while (bus.ack === '0 && w < 200) begin
      w++;
      tick();
    end
    chk("mid_ack", 32'(bus.ack), 32'h4);
    model_last = 2;
    bus.req = '0;
    for (int c = 1; c <= 5 * CD - 3; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_last = N - 1;
    chk("mid_rst_tx", 32'(bus.tx), 1);
    chk("mid_rst_bsy", 32'(bus.bsy), 0);
    chk("mid_rst_ack", 32'(bus.ack), 0);
    chk("mid_rst_gnt", 32'(bus.gnt_id), 0);
    bus.req = 4'b1001;
    run_frame(1'b0, '0, -1, -1, w);
    chk("post_rst_gnt0", 32'(bus.gnt_id), 0);
    run_frame(1'b0, '0, -1, -1, w);
    // requester 3 pulses during a frame and leaves before IDLE
    bus.data_in = $urandom;
    bus.req = 4'b0010;
    run_frame(1'b0, 4'b1000, 5, 30, w);
    acks = 0;
    for (int c = 0; c < 3 * CD; c++) begin
      if (bus.ack !== '0 || bus.bsy !== 1'b0) acks++;
      tick();
    end
    chk("drop_no_grant", 32'(acks), 0);
    // parity-bearing byte 07
    bus.data_in[7:0] = 8'h07;
    bus.req = 4'b0001;
    run_frame(1'b0, '0, -1, -1, w);
    // random requests and data
    bus.req = '0;
    for (int it = 0; it < 10; it++) begin
      bus.data_in = $urandom;
      bus.req = bus.req | N'($urandom_range(1, (1 << N) - 1));
      run_frame(1'b0, '0, -1, -1, w);
    end
    bus.req = '0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmit serializer among `N_REQ` on-chip requesters. A round-robin arbiter grants one requester at a time, latches its byte and shifts it out on `tx` as a standard 8N1 frame: start bit 0, eight data bits LSB first, stop bit 1. An optional parity bit can be compiled in. The block sits on the transmit side opposite the `uart_controller` receiver and runs from the system clock, with an internal baud divider.

## Interface

Parameters:

- `N_REQ`, 4: number of requesters, range 2..8.
- `CLK_DIV`, 16: system clock cycles per bit period, minimum 2.

Ports:

- `clk` input 1: system clock; all logic on posedge.
- `rst` input 1: synchronous, active-high reset.
- `req` input `N_REQ`: per-requester request. The requester holds it high with stable data until it sees `ack`.
- `data_in` input `8*N_REQ`: byte for requester k is `data_in[8k+7:8k]`.
- `ack` output `N_REQ`: one-cycle, one-hot pulse when a requester's byte is latched.
- `gnt_id` output `$clog2(N_REQ)`: index of the requester whose frame is in flight. Valid while `bsy` is high.
- `tx` output 1: serial line, idle high.
- `bsy` output 1: high from the START state through the end of STOP.

## Operation

States: IDLE, START, DATA, PARITY (only with the macro), STOP.

- **IDLE**
  - `tx`=1, `bsy`=0.
  - If any `req` is high, search from `last+1` modulo `N_REQ`; the first requester found is the winner.
  - In the same cycle: latch the winner's byte into the shift register, set `gnt_id` and `last`, pulse `ack[winner]` on the next cycle, and go to START.
- **START**: `tx`=0 for `CLK_DIV` cycles.
- **DATA**
  - `tx`=`shift[0]`; shift right at the end of each bit period.
  - Eight bit periods, counted by a 3-bit bit index.
- **PARITY**: `tx`=^byte (even parity) for one bit period.
- **STOP**: `tx`=1 for one bit period, then go to IDLE.

Bit timing:

- The divider counter, `$clog2(CLK_DIV)` bits wide, is cleared on entry to START.
- It generates a tick on count `CLK_DIV-1`, then wraps to 0.
- State and bit-index advances happen only on a tick.

Round-robin and fairness:

- `last` resets to `N_REQ-1`, so req0 has top priority after reset.
- A requester that is continuously held high waits at most `N_REQ-1` frames.

Boundary conditions:

- A `req` that drops before it is granted is simply not granted. No error is flagged.
- A `req` that rises while `bsy` is high waits for IDLE. It is never lost while held.
- `req[k]` still high in the cycle after `ack[k]` is treated as a new request for the next frame.
- Reset mid-frame: the frame is aborted. On the next edge `tx`=1, `bsy`=0, `ack`=0, `gnt_id`=0, `last`=`N_REQ-1`, state is IDLE, and the shift register is 0.

## Timing

- Reset values: `tx`=1, `bsy`=0, `ack`=0, `gnt_id`=0.
- Arbitration latency:
  - `req` seen in IDLE at edge n: `ack` is high and `tx` falls at edge n+1.
  - `bsy` rises at edge n+1.
- Frame length: `10*CLK_DIV` cycles, or `11*CLK_DIV` with parity. All outputs are registered.
- Back-to-back frames: STOP exits to IDLE, which lasts at least 1 cycle. Minimum inter-frame gap is 1 clk of `tx`=1, on top of the stop bit.
- `bsy` falls on the same edge that enters IDLE.

## Configuration

- `UART_TX_ARB_PARITY_EN` defined:
  - PARITY state is present; an even parity bit is inserted between DATA and STOP.
  - The frame is 11 bit periods.
- Not defined:
  - The PARITY state and its logic are absent; STOP follows DATA directly.
  - The frame is 10 bit periods.

## Structure

- The shared package `uart_pkg` holds:
  - the state enum `uart_tx_state_t`;
  - constants `UART_DATA_BITS`=8, `UART_START_BIT`=1'b0, `UART_STOP_BIT`=1'b1, `UART_IDLE_LEVEL`=1'b1.
- Sub-module `uart_baud_tick`:
  - Inputs: `clk`, `rst`, `clr`. Output: `tick`. Parameter: `CLK_DIV`.
  - Provides the divider; the FSM and the arbiter stay in `uart_tx_arbiter`.

## Test plan

Directed benches use `CLK_DIV`=4 and `N_REQ`=4.

1. **Single request.** `req[1]`=1 with byte 8'hA5 in IDLE → `ack[1]` pulses for 1 cycle and `gnt_id`=1. `tx` per bit period is 0,1,0,1,0,0,1,0,1,1, and `bsy` is high for exactly 40 cycles.
2. **Simultaneous requests after reset.** `req[0]` and `req[2]` rise together → req0's frame is sent first, then req2's. The two frames are separated by exactly 1 idle cycle.
3. **Fairness.** All four `req` held high for 8 frames → grant order is 0,1,2,3,0,1,2,3.
4. **Reset mid-frame.** `rst` pulsed during the DATA bit 3 period → the next edge gives `tx`=1, `bsy`=0, `ack`=0. The next request of req0 is granted ahead of req3.
5. **Request dropped before grant.** `req[3]` asserted during another frame and dropped before IDLE → no `ack[3]` and no frame for requester 3.
6. **Parity, macro defined.** Byte 8'h07 → the parity bit period is 1, and `bsy` is high for 44 cycles.
